// File: rtl/pgr_uart_rx_pkg.sv
// Shared definitions for the UART receive front end: FSM states, frame width
// and baud-timing helpers.
package pgr_uart_rx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Clock cycles per serial bit, truncated.
    function automatic int uart_bit_cnt(input int clk_mhz, input int baud);
        return (clk_mhz * 1_000_000) / baud;
    endfunction

    function automatic int uart_half_cnt(input int clk_mhz, input int baud);
        return uart_bit_cnt(clk_mhz, baud) / 2;
    endfunction

endpackage

// File: rtl/pgr_uart_rx_sync_fifo.sv
// Synchronous show-ahead FIFO with a separate occupancy counter; a push refused
// because the FIFO is full raises a one-cycle overflow pulse on the next cycle.
module pgr_uart_rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign full    = (level == LVL_FULL);
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    // NOTE: the storage array is deliberately not reset; emptiness is tracked by level alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            overflow <= push && !do_push;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pgr_uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// show-ahead byte FIFO; framing/parity/overflow errors are one-cycle pulses.
module pgr_uart_rx_fifo #(
    parameter int CLK_FREQ   = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx,
    output logic [7:0]                  rx_fifo_rd_data,
    output logic                        rx_fifo_rd_data_valid,
    input  logic                        rx_fifo_rd_data_req,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow
);
    import pgr_uart_rx_pkg::*;

    localparam int BIT_CNT = uart_bit_cnt(CLK_FREQ, BAUD_RATE);
    localparam int HALF    = uart_half_cnt(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      sync1;
    logic                      rx_s;
    rx_state_t                 state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      push;
`ifdef UART_RX_PARITY_EN
    logic                      par_bit;
    logic                      par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // NOTE: all state uses <= so every flop sees pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            sync1     <= uart_rx;
            rx_s      <= sync1;
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            if (cnt != '0) cnt <= cnt - 1'b1;

            case (state)
                IDLE: if (!rx_s) begin
                    cnt   <= CNT_HALF;
                    state <= START;
                end
                START: if (cnt == '0) begin
                    if (!rx_s) begin
                        cnt     <= CNT_BIT;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: if (cnt == '0) begin
                    shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
                    cnt     <= CNT_BIT;
                    bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == LAST_BIT) state <= PARITY;
`else
                    if (bit_idx == LAST_BIT) state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt == '0) begin
                    par_bit <= rx_s;
                    cnt     <= CNT_BIT;
                    state   <= STOP;
                end
`endif
                STOP: if (cnt == '0) begin
                    if (!rx_s) begin
                        frame_err <= 1'b1;
                        state     <= WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if ((^shift) != par_bit) begin
                        par_err_q <= 1'b1;
                        state     <= IDLE;
                    end
`endif
                    else begin
                        push  <= 1'b1;
                        state <= IDLE;
                    end
                end
                // A held-low line (break) must return high before a new start bit counts.
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    pgr_uart_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift),
        .pop       (rx_fifo_rd_data_req),
        .head      (rx_fifo_rd_data),
        .valid     (rx_fifo_rd_data_valid),
        .level     (fifo_level),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_pgr_uart_rx_fifo.sv
// Scoreboard bench for pgr_uart_rx_fifo; frames are driven on the falling clock
// edge and a monitor drains and compares bytes whenever draining is enabled.
`timescale 1ns/1ps
module tb_pgr_uart_rx_fifo;
    localparam int CLK_FREQ  = 50;
    localparam int BAUD_RATE = 921600;
    localparam int DEPTH     = 16;
    localparam int BIT       = 54;   // 50_000_000 / 921600, truncated
    localparam int HALF      = 27;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Falling edges from driving the start bit to the rising edge that writes the FIFO.
    localparam int PUSH_DLY = HALF + NBITS * BIT + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rd_data;
    logic       valid;
    logic       req;
    logic       mon_req = 1'b0;
    logic       stim_req = 1'b0;
    logic [4:0] level;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_frame = 0;
    int n_par   = 0;
    int n_ovf   = 0;
    bit drain_en = 1'b0;
    logic [7:0] exp_q[$];

    assign req = mon_req | stim_req;

    always #10 clk = ~clk;

    pgr_uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .uart_rx               (uart_rx),
        .rx_fifo_rd_data       (rd_data),
        .rx_fifo_rd_data_valid (valid),
        .rx_fifo_rd_data_req   (req),
        .fifo_level            (level),
        .frame_err             (frame_err),
        .parity_err            (parity_err),
        .overflow              (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Shifts out frame[0..n-1] LSB first; the last bit stays on the line.
    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            uart_rx = frame[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
        send_bits({stop_bit, ^d, d, 1'b0}, 11);
`else
        send_bits({1'b0, stop_bit, d, 1'b0}, 10);
`endif
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_empty(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || valid !== 1'b0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, (t < 200) ? 1 : 0, 1);
        settle();
    endtask

    // Monitor: counts error pulses and, while draining, pops and compares the head byte.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1)  n_frame++;
            if (parity_err === 1'b1) n_par++;
            if (overflow === 1'b1)   n_ovf++;
            if (drain_en && valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_extra: got %02h, expected no byte", rd_data);
                end else begin
                    check("rx_byte", rd_data, exp_q.pop_front());
                end
                mon_req = 1'b1;
            end else begin
                mon_req = 1'b0;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_f, base_p, base_o;
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_data", rd_data, 0);
        check("rst_pulses", {frame_err, parity_err, overflow}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte, held then read with one req
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        settle();
        check("a5_valid", valid, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_level", level, 1);
        drain_en = 1'b1;
        wait_empty("a5_drain");
        check("a5_valid_after", valid, 0);
        check("a5_level_after", level, 0);
        drain_en = 1'b0;

        // 17 bytes with no reads: last one overflows
        base_o = n_ovf;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        settle();
        check("fill_level", level, 16);
        check("fill_no_ovf", n_ovf - base_o, 0);
        send_byte(8'h10, 1'b1);
        settle();
        check("ovf_once", n_ovf - base_o, 1);
        check("ovf_level", level, 16);
        drain_en = 1'b1;
        wait_empty("ovf_drain");
        check("ovf_level_after", level, 0);

        // Short low glitch on an idle line
        base_f = n_frame; base_p = n_par; base_o = n_ovf;
        uart_rx = 1'b0;
        repeat (15) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_level", level, 0);
        check("glitch_pulses", (n_frame - base_f) + (n_par - base_p) + (n_ovf - base_o), 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_empty("glitch_next_byte");

        // Stop bit low, line held low (break), then a good byte
        base_f = n_frame;
        send_byte(8'h55, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (BIT) @(negedge clk);
        check("frame_pulse", n_frame - base_f, 1);
        check("frame_level", level, 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_empty("frame_next_byte");
        check("frame_pulse_total", n_frame - base_f, 1);
        drain_en = 1'b0;

        // Full FIFO with a pop in the same cycle as the push of 0x7E
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h80 + 8'(i));
            send_byte(8'h80 + 8'(i), 1'b1);
        end
        settle();
        check("full_level", level, 16);
        base_o = n_ovf;
        exp_q.push_back(8'h7E);
        fork
            send_byte(8'h7E, 1'b1);
            begin
                repeat (PUSH_DLY) @(negedge clk);
                check("simul_head", rd_data, exp_q.pop_front());
                stim_req = 1'b1;
                @(negedge clk);
                stim_req = 1'b0;
            end
        join
        settle();
        check("simul_level", level, 16);
        check("simul_no_ovf", n_ovf - base_o, 0);
        drain_en = 1'b1;
        wait_empty("simul_drain");

`ifdef UART_RX_PARITY_EN
        // 0x01 has odd weight: parity bit 0 is wrong, 1 is right
        base_p = n_par;
        send_bits({1'b1, 1'b0, 8'h01, 1'b0}, 11);
        settle();
        check("par_pulse", n_par - base_p, 1);
        check("par_level", level, 0);
        exp_q.push_back(8'h01);
        send_bits({1'b1, 1'b1, 8'h01, 1'b0}, 11);
        wait_empty("par_good");
        check("par_pulse_total", n_par - base_p, 1);
`endif
        drain_en = 1'b0;

        // Reset mid-frame flushes the FIFO and the partial byte
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        settle();
        check("pre_rst_level", level, 1);
        exp_q.delete();
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (3 * BIT) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        settle();
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", valid, 0);
        drain_en = 1'b1;
        exp_q.push_back(8'h22);
        send_byte(8'h22, 1'b1);
        wait_empty("post_rst_byte");

`ifdef UART_RX_PARITY_EN
        check("total_par", n_par, 1);
`else
        check("total_par", n_par, 0);
`endif
        check("total_frame", n_frame, 1);
        check("total_ovf", n_ovf, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pgr_uart_rx_fifo.md
# pgr_uart_rx_fifo

UART receive front end for the UART-to-APB bridge: it synchronises the serial `uart_rx` line, deserialises 8N1 frames at a fixed baud rate and buffers the received bytes in a show-ahead FIFO. It sits directly upstream of the APB command parser/controller and drives that controller's `rx_fifo_rd_data` / `rx_fifo_rd_data_valid` / `rx_fifo_rd_data_req` interface. Framing, overflow and (optional) parity errors are reported as single-cycle status pulses.

## Interface
- `CLK_FREQ`, 50: clock frequency in MHz (integer).
- `BAUD_RATE`, 115200: serial bit rate in bit/s.
- `FIFO_DEPTH`, 16: byte entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input; idle high.
- `rx_fifo_rd_data`  out  8  byte at FIFO head; valid while `rx_fifo_rd_data_valid`=1.
- `rx_fifo_rd_data_valid`  out  1  FIFO non-empty.
- `rx_fifo_rd_data_req`  in  1  pop the head byte; ignored while valid=0.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (0 when the parity feature is compiled out).
- `overflow`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

## Operation
- Reset values: all outputs 0, FIFO empty, FSM = IDLE, synchroniser flops = 1 (no false start after reset).
- `uart_rx` passes through a 2-flop synchroniser; the FSM sees `rx_s` (2 cycles of delay).
- `BIT_CNT` = CLK_FREQ*1_000_000/BAUD_RATE (integer division, 434 at the defaults); `HALF` = BIT_CNT/2 (217). The baud counter is wide enough for BIT_CNT-1.
- FSM states:
  - IDLE: on `rx_s`=0, load counter and go to START.
  - START: after HALF cycles, sample `rx_s`. If 0, go to DATA. If 1 (glitch), go to IDLE.
  - DATA: sample every BIT_CNT cycles at mid-bit, LSB first, 8 bits. Then go to PARITY if enabled, otherwise to STOP.
  - PARITY: sample one bit, then go to STOP.
  - STOP: sample at mid-bit.
    - 1 and parity ok: push the byte, return to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
    - 1 with a parity error: pulse `parity_err`, discard the byte, return to IDLE.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This covers break conditions.
- FIFO:
  - Show-ahead operation: `rx_fifo_rd_data` always presents the head entry.
  - A pop happens when `rx_fifo_rd_data_req` & valid.
  - Push when full with no pop in the same cycle: the byte is dropped and `overflow` pulses. The FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted and the level stays at FIFO_DEPTH.
  - Push and pop in the same cycle while empty: the pop is ignored and the level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH; the level is held in a separate counter.
- Reset during a frame: the partial byte is lost, the FIFO is emptied, and the FSM returns to IDLE in the next cycle.

## Timing
- Push occurs on the cycle after the mid-stop-bit sample. `rx_fifo_rd_data_valid` and `fifo_level` update on the following edge, which is 1 cycle after the push.
- Pop: data, valid and level reflect the new head 1 cycle after `req` is sampled. `req` may be held high to drain one byte per cycle.
- Error pulses assert on the cycle after the faulty sample and last exactly 1 cycle.
- Start-edge to byte-valid latency: 2 (sync) + HALF + 9*BIT_CNT (+BIT_CNT with parity) + 2 cycles.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1; the even-parity bit follows D7.
  - A mismatch discards the byte and pulses `parity_err`.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8N1 and the PARITY state is absent.
  - `parity_err` is tied to 0.

## Structure
- Package `pgr_uart_rx_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - `UART_DATA_BITS`=8;
  - the BIT_CNT/HALF calculation as a constant function.
- One sub-module, `pgr_uart_rx_sync_fifo`: parameterised synchronous show-ahead FIFO with push/pop/level. The deserialiser FSM stays in the top module.

## Test plan
Defaults apply: 50 MHz clock, 115200 baud, bit time 434 cycles, depth 16.
- Single byte 0xA5 → valid=1 and rd_data=0xA5 with level=1. Then req for 1 cycle → valid=0, level=0.
- 17 back-to-back bytes 0x00..0x10 with no reads → `overflow` pulses exactly once (at 0x10) and level=16. Draining returns 0x00..0x0F in order.
- Low glitch of 100 cycles on an idle line → no push, no error pulse, FSM back in IDLE.
- Byte 0x55 with stop bit low, then line low for 2 bit times, then byte 0x3C → one `frame_err` pulse and only 0x3C in the FIFO.
- FIFO full, with req asserted in the same cycle as the push of 0x7E → no overflow, level stays 16, and 0x7E becomes the last entry.
- With `UART_RX_PARITY_EN`: byte 0x01 with parity bit 0 → `parity_err` pulse and no push. The same byte with parity bit 1 → pushed.
